// File: rtl/dc_vga_pkg.sv
// Shared types and constants for the VGA pixel streamer.
package dc_vga_pkg;

  localparam int PIXEL_DATA_WIDTH = 24;

  // One pixel as carried on pixel_data: {B[23:16], G[15:8], R[7:0]}.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  // Streamer control states (also visible on the dbg_state output).
  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } stream_state_e;

  // One FIFO entry: start-of-frame marker plus the pixel itself.
  typedef struct packed {
    logic   sof;
    pixel_t pixel;
  } fifo_entry_t;

endpackage

// File: rtl/dc_vga_pixel_streamer_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rdata in the cycle after it is pushed into an empty FIFO; peek_data shows
// the entry behind the head so the owner can look one pop ahead.
module dc_sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [WIDTH-1:0]         peek_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign peek_data = mem_q[rd_ptr_q + AW'(1)];

  // Pointer and occupancy update; a push into a full FIFO is ignored even
  // when a pop happens in the same cycle.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dc_vga_pixel_streamer.sv
// Frame-aligned pixel source for the VGA output controller.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (upstream: in_valid/in_ready, downstream: pixel_valid/pixel_ready);
// valid never depends on ready in the same cycle.
module dc_vga_pixel_streamer #(
  parameter int H_ACTIVE         = 640,
  parameter int V_ACTIVE         = 480,
  parameter int PIXEL_DATA_WIDTH = dc_vga_pkg::PIXEL_DATA_WIDTH,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                        iVGA_CLK,
  input  logic                        iRST_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PIXEL_DATA_WIDTH-1:0] in_data,
  input  logic                        in_sof,
  input  logic                        v_blank,
  output logic                        pixel_valid,
  input  logic                        pixel_ready,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel_data,
  output logic                        frame_done,
  output logic                        underflow_err,
  output logic                        sof_err,
  input  logic                        err_clr,
  output logic [1:0]                  dbg_state
);

  import dc_vga_pkg::*;

  localparam int EW = PIXEL_DATA_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  stream_state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          keep_q, keep_d;
  logic          frame_done_q, frame_done_d;
  logic          sof_err_q, sof_err_d;
  logic          und_err_q, und_err_d;
  logic          set_sof, set_und;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] head, peek;
  logic          head_sof, peek_sof, next_sof, at_origin;

  dc_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (iVGA_CLK),
    .rst_n     (iRST_n),
    .push      (fifo_push),
    .wdata     ({in_sof, in_data}),
    .pop       (fifo_pop),
    .rdata     (head),
    .peek_data (peek),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_sof      = head[EW-1];
  assign peek_sof      = peek[EW-1];
  assign at_origin     = (x_q == '0) && (y_q == '0);
  assign pixel_data    = pixel_valid ? head[PIXEL_DATA_WIDTH-1:0] : '0;
  assign frame_done    = frame_done_q;
  assign sof_err       = sof_err_q;
  assign underflow_err = und_err_q;
  assign dbg_state     = state_q;

  // Next-state, FIFO control, raster position and error flags.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    keep_d       = keep_q;
    frame_done_d = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    pixel_valid  = 1'b0;
    in_ready     = ~fifo_full;
    set_sof      = 1'b0;
    set_und      = 1'b0;
    next_sof     = 1'b0;
    case (state_q)
      SEEK: begin
        // Once an SOF pixel has been written, the rest of that frame must be
        // kept too, so keep_q opens the write path until the SOF reaches the
        // head. Only then can the FIFO fill up and need to push back.
        in_ready  = ~(keep_q & fifo_full);
        fifo_push = in_valid & in_ready & (in_sof | keep_q);
        if (in_valid && in_ready && in_sof) keep_d = 1'b1;
        if (!fifo_empty) begin
          if (head_sof) begin
            state_d = ARMED;
            keep_d  = 1'b0;
          end else begin
            fifo_pop = 1'b1;
          end
        end
      end
      ARMED: begin
        fifo_push = in_valid & ~fifo_full;
        if (v_blank && ((fifo_count >= CW'(FIFO_DEPTH / 2)) || fifo_full))
          state_d = STREAM;
      end
      STREAM: begin
        fifo_push   = in_valid & ~fifo_full;
        pixel_valid = ~fifo_empty;
        // Head after this pop: the entry behind it, or the pixel being pushed
        // right now when the FIFO holds only the head.
        next_sof = (fifo_count > CW'(1)) ? peek_sof : (fifo_push & in_sof);
        if (pixel_valid && pixel_ready) begin
          fifo_pop = 1'b1;
          if (head_sof && !at_origin) begin
            set_sof = 1'b1;
            x_d     = '0;
            y_d     = '0;
            state_d = ARMED;
          end else if (x_q == X_LAST && y_q == Y_LAST) begin
            frame_done_d = 1'b1;
            x_d          = '0;
            y_d          = '0;
            state_d      = next_sof ? ARMED : SEEK;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end else if (pixel_ready && fifo_empty) begin
          set_und = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase
    sof_err_d = err_clr ? 1'b0 : (sof_err_q | set_sof);
    und_err_d = err_clr ? 1'b0 : (und_err_q | set_und);
  end

  // Control state registers.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= SEEK;
      x_q          <= '0;
      y_q          <= '0;
      keep_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      und_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      keep_q       <= keep_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      und_err_q    <= und_err_d;
    end
  end

endmodule

// File: tb/tb_dc_vga_pixel_streamer.sv
// Bench for dc_vga_pixel_streamer with an 8x4 frame and an 8-entry FIFO.
module tb_dc_vga_pixel_streamer;
  import dc_vga_pkg::*;

  localparam int H = 8, V = 4, D = 8, PW = 24, W = PW + 1, FRAME = H * V;

  logic          clk = 1'b0, iRST_n = 1'b0;
  logic          in_valid = 1'b0, in_sof = 1'b0, v_blank = 1'b0, err_clr = 1'b0;
  logic          pixel_ready = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          in_ready, pixel_valid, frame_done, underflow_err, sof_err;
  logic [PW-1:0] pixel_data;
  logic [1:0]    dbg_state;

  dc_vga_pixel_streamer #(.H_ACTIVE(H), .V_ACTIVE(V), .PIXEL_DATA_WIDTH(PW), .FIFO_DEPTH(D)) dut (
    .iVGA_CLK(clk), .iRST_n(iRST_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .v_blank(v_blank), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_data(pixel_data), .frame_done(frame_done), .underflow_err(underflow_err),
    .sof_err(sof_err), .err_clr(err_clr), .dbg_state(dbg_state));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Model: a frame is FRAME consecutive pops counted from the SOF pixel;
  // an SOF that pops early restarts the count at zero after its own pop.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  bit mon_en = 0, drv_keep = 0, exp_fd = 0;
  int pos = 0, pops = 0, fd_seen = 0, sof_events = 0, ir_low_seen = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("frame_done", frame_done, exp_fd);
      if (frame_done) fd_seen++;
      check("in_ready_level", in_ready, exp_q.size() != D);
      if (!in_ready) ir_low_seen++;
      exp_fd = 0;
      if (pixel_valid && pixel_ready) begin
        check("model_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pixel_data", pixel_data, e[PW-1:0]);
          pops++;
          if (e[PW] && pos != 0) begin
            sof_events++;
            pos = 0;
          end else if (pos == FRAME - 1) begin
            exp_fd = 1;
            pos = 0;
          end else begin
            pos++;
          end
        end
      end
      if (in_valid && in_ready && drv_keep) exp_q.push_back({in_sof, in_data});
    end
  end

  // ---------------- drivers ----------------
  int pr_mode = 0;   // 0 idle, 1 always, 2 random 1-in-3, 3 from table
  logic tbl_pr = 1'b0;

  always @(posedge clk) begin
    #2;
    case (pr_mode)
      1:       pixel_ready = 1'b1;
      2:       pixel_ready = ($urandom_range(0, 2) == 0);
      3:       pixel_ready = tbl_pr;
      default: pixel_ready = 1'b0;
    endcase
  end

  task automatic do_reset();
    mon_en = 0;
    iRST_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    v_blank = 1'b0; err_clr = 1'b0; pr_mode = 0; tbl_pr = 1'b0;
    repeat (2) @(posedge clk);
    #1 iRST_n = 1'b1;
    exp_q.delete();
    pos = 0; exp_fd = 0; pops = 0; fd_seen = 0; sof_events = 0; ir_low_seen = 0;
  endtask

  // Push n pixels back to back; the first carries in_sof when sof_first.
  task automatic push_items(input logic [PW-1:0] base, input int n, input bit sof_first,
                            input bit keep, input bit rnd);
    bit acc;
    int budget;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sof   = sof_first && (i == 0);
      in_data  = rnd ? PW'($urandom) : base + PW'(i);
      drv_keep = keep;
      acc = 0;
      budget = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      check("push_accepted", acc, 1);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    int b = 0;
    while (pops < target && b < 3000) begin
      @(posedge clk);
      b++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("pop_count", pops, target);
  endtask

  // ---------------- table for the pre-SOF / arming sequence ----------------
  typedef struct {
    logic iv; logic isof; logic [PW-1:0] idata; logic vb; logic pr;
    logic exp_pv; logic exp_ir; logic [PW-1:0] exp_pd;
  } vec_t;
  vec_t tbl[18];

  initial begin
    // Rows 0-4: garbage without SOF, discarded in SEEK.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, PW'(32'h0F0000 + i), 1'b0, 1'b0, 1'b0, 1'b1, '0};
    tbl[5]  = '{1'b1, 1'b1, 24'h000100, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    tbl[6]  = '{1'b1, 1'b0, 24'h000101, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    tbl[7]  = '{1'b1, 1'b0, 24'h000102, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};  // blanking, 2 entries
    tbl[8]  = '{1'b1, 1'b0, 24'h000103, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0};  // blanking, 3 entries
    tbl[9]  = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1, 24'h0};  // 4 entries, no blanking
    tbl[10] = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 24'h0};
    tbl[11] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 24'h0};  // arms here
    tbl[12] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 1'b1, 24'h000100};
    tbl[13] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 1'b1, 24'h000100};
    tbl[14] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 1'b1, 24'h000101};
    tbl[15] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 1'b1, 24'h000102};
    tbl[16] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 1'b1, 24'h000103};
    tbl[17] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 24'h0};

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_pixel_data", pixel_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_errors", {underflow_err, sof_err}, 0);
    check("rst_state", dbg_state, SEEK);

    // ---- nominal frame: data = index, ready held high ----
    do_reset();
    mon_en = 1; v_blank = 1'b1; pr_mode = 1;
    push_items(24'd0, FRAME, 1, 1, 0);
    wait_pops(FRAME);
    check("nom_frame_done_count", fd_seen, 1);
    check("nom_errors", {underflow_err, sof_err}, 0);

    // ---- pre-SOF garbage and arming thresholds (table) ----
    do_reset();
    pr_mode = 3;
    for (int r = 0; r < 18; r++) begin
      in_valid = tbl[r].iv; in_sof = tbl[r].isof; in_data = tbl[r].idata;
      v_blank = tbl[r].vb; tbl_pr = tbl[r].pr;
      @(negedge clk);
      check($sformatf("tbl%0d_pixel_valid", r), pixel_valid, tbl[r].exp_pv);
      check($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].exp_ir);
      check($sformatf("tbl%0d_pixel_data", r), pixel_data, tbl[r].exp_pd);
      @(posedge clk);
      #1;
    end

    // ---- backpressure: random ready, random data, two frames ----
    do_reset();
    mon_en = 1; v_blank = 1'b1; pr_mode = 2;
    push_items('0, FRAME, 1, 1, 1);
    push_items('0, FRAME, 1, 1, 1);
    wait_pops(2 * FRAME);
    check("bp_frame_done_count", fd_seen, 2);
    check("bp_in_ready_dropped", ir_low_seen != 0, 1);
    check("bp_errors", {underflow_err, sof_err}, 0);

    // ---- underflow after 10 pixels, then a clean frame ----
    do_reset();
    mon_en = 1; v_blank = 1'b1; pr_mode = 1;
    push_items(24'h000500, 10, 1, 1, 0);
    wait_pops(10);
    check("und_flag", underflow_err, 1);
    check("und_state", dbg_state, SEEK);
    check("und_pixel_valid", pixel_valid, 0);
    check("und_sof_err", sof_err, 0);
    pos = 0;  // abandoned frame
    push_items(24'h000600, FRAME, 1, 1, 0);
    wait_pops(10 + FRAME);
    check("und_frame_done_count", fd_seen, 1);
    check("und_flag_sticky", underflow_err, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("und_err_clr", underflow_err, 0);

    // ---- early SOF: 12 pixels, then a new frame ----
    // The early SOF pixel is delivered and the position restarts after it,
    // so the frame_done pop is the 32nd pop after it (33 pixels pushed).
    do_reset();
    mon_en = 1; v_blank = 1'b1; pr_mode = 1;
    push_items(24'h000200, 12, 1, 1, 0);
    push_items(24'h000300, FRAME + 1, 1, 1, 0);
    wait_pops(12 + FRAME + 1);
    check("esof_sof_events", sof_events, 1);
    check("esof_flag", sof_err, 1);
    check("esof_frame_done_count", fd_seen, 1);
    check("esof_underflow", underflow_err, 0);

    // ---- asynchronous reset in the middle of STREAM ----
    mon_en = 0; pr_mode = 0; v_blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_sof = (i == 0); in_data = 24'h000700 + PW'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    check("mid_stream_state", dbg_state, STREAM);
    check("mid_pixel_valid", pixel_valid, 1);
    check("mid_pixel_data", pixel_data, 24'h000700);
    check("mid_in_ready_full", in_ready, 0);
    @(posedge clk);
    #3 iRST_n = 1'b0;
    #1;
    check("arst_pixel_valid", pixel_valid, 0);
    check("arst_pixel_data", pixel_data, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_state", dbg_state, SEEK);
    check("arst_errors", {underflow_err, sof_err}, 0);
    repeat (2) @(posedge clk);
    #1 iRST_n = 1'b1;
    @(negedge clk);
    check("post_rst_pixel_valid", pixel_valid, 0);
    check("post_rst_frame_done", frame_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
